// File: rtl/fsm_core_sequencer_if.sv
// Controller-side handshake bundle for fsm_core_sequencer.
// The test controller drives start/abort/seed; the sequencer returns status and the signature.
interface fsm_core_sequencer_if;
  logic        start;
  logic        abort;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_cnt;

  modport master (
    output start, abort, seed,
    input  busy, done, signature, vec_cnt
  );

  modport slave (
    input  start, abort, seed,
    output busy, done, signature, vec_cnt
  );
endinterface

// File: rtl/fsm_core_sequencer.sv
// Drives one registered FSM core with LFSR stimulus and folds its outputs into a 16-bit MISR.
// Sequence per run: optional WARM flush, NUM_VEC RUN vectors, DRAIN of the capture pipe, DONE pulse.
module fsm_core_sequencer #(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 5,
  parameter int NUM_VEC  = 64,
  parameter int LAT      = 1,
  parameter int WARM_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_core_sequencer_if.slave ctl,
  input  logic [OUT_W-1:0]   core_out,
  output logic [IN_W-1:0]    core_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WARM  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_VEC  = 16'(NUM_VEC - 1);
  localparam logic [15:0] VEC_MAX   = 16'(NUM_VEC);
  localparam logic [7:0]  WARM_LAST = 8'(WARM_CYC - 1);

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    lfsr;
  logic [15:0]    signature;
  logic [15:0]    vec_cnt;
  logic [7:0]     warm_cnt;
  logic [LAT-1:0] vpipe;
  logic           issue;
  logic           capture;
  logic           pipe_empty;
  logic           last_vec;
  logic           warm_last;
  logic           busy;
  logic           done;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [OUT_W-1:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ 16'(d);
  endfunction

  assign issue      = (state == RUN) && !ctl.abort;
  assign capture    = vpipe[LAT-1];
  assign pipe_empty = (vpipe == '0);
  assign last_vec   = (vec_cnt == LAST_VEC);
  assign warm_last  = (warm_cnt == WARM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    state_nxt = state;
    if (ctl.abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ctl.start) state_nxt = (WARM_CYC == 0) ? RUN : WARM;
        WARM:    if (warm_last) state_nxt = RUN;
        RUN:     if (last_vec) state_nxt = DRAIN;
        DRAIN:   if (pipe_empty) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      WARM, RUN, DRAIN: busy = 1'b1;
      DONE:             done = 1'b1;
      default:          ;
    endcase
  end

  // The valid pipe marks, per vector issued, the edge at which its core response is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in   <= '0;
      lfsr      <= 16'h0001;
      signature <= 16'h0000;
      vec_cnt   <= 16'h0000;
      warm_cnt  <= 8'h00;
      vpipe     <= '0;
    end else if (ctl.abort) begin
      core_in <= '0;
      vpipe   <= '0;
    end else begin
      vpipe <= (vpipe << 1) | LAT'(issue);
      if (capture) begin
        signature <= misr_step(signature, core_out);
      end
      unique case (state)
        IDLE: begin
          core_in <= '0;
          if (ctl.start) begin
            lfsr      <= (ctl.seed == 16'h0000) ? 16'h0001 : ctl.seed;
            signature <= 16'h0000;
            vec_cnt   <= 16'h0000;
            warm_cnt  <= 8'h00;
          end
        end
        WARM: begin
          core_in  <= '0;
          warm_cnt <= warm_cnt + 8'd1;
        end
        RUN: begin
          core_in <= lfsr[IN_W-1:0];
          lfsr    <= lfsr_step(lfsr);
          if (vec_cnt != VEC_MAX) begin
            vec_cnt <= vec_cnt + 16'd1;
          end
        end
        default: core_in <= '0;
      endcase
    end
  end

  assign ctl.busy      = busy;
  assign ctl.done      = done;
  assign ctl.signature = signature;
  assign ctl.vec_cnt   = vec_cnt;

  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_busy_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: tb/tb_fsm_core_sequencer.sv
// Self-checking bench: randomized seeds through a toy core, checked against a list-based run model.
module tb_fsm_core_sequencer;

  localparam int M_WARM = 4;
  localparam int M_NV   = 64;
  localparam int M_LAT  = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fsm_core_sequencer_if m_if ();
  fsm_core_sequencer_if s_if ();

  logic [2:0] m_core_in;
  logic [4:0] m_core_out;
  logic [4:0] core_reg;
  logic       tied;
  logic [4:0] tie_val;
  logic [2:0] s_core_in;
  logic [4:0] s_core_out;

  logic [2:0] got_vecs[$];
  logic [2:0] exp_vecs[$];
  logic [2:0] ref_vecs[$];

  fsm_core_sequencer #(
    .IN_W(3), .OUT_W(5), .NUM_VEC(M_NV), .LAT(M_LAT), .WARM_CYC(M_WARM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctl(m_if), .core_out(m_core_out), .core_in(m_core_in)
  );

  fsm_core_sequencer #(
    .IN_W(3), .OUT_W(5), .NUM_VEC(2), .LAT(1), .WARM_CYC(0)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .ctl(s_if), .core_out(s_core_out), .core_in(s_core_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy core: arbitrary 3->5 mix with one register stage, giving two cycles from core_in to sample.
  function automatic logic [4:0] core_fn(input logic [2:0] v);
    return {v[2] ^ v[0], v[1], v[0], ~v[2], v[1] ^ v[2]};
  endfunction

  always @(posedge clk) core_reg <= core_fn(m_core_in);
  assign m_core_out = tied ? tie_val : core_reg;
  assign s_core_out = 5'h01;

  // Reference: list of vectors from the LFSR rule, then fold each expected response into the MISR.
  task automatic model_run(input logic [15:0] sd, input int n, output logic [15:0] sig);
    logic [15:0] l;
    logic [4:0]  d;
    l   = (sd == 16'h0000) ? 16'h0001 : sd;
    sig = 16'h0000;
    exp_vecs.delete();
    for (int i = 0; i < n; i++) begin
      exp_vecs.push_back(l[2:0]);
      d   = tied ? tie_val : core_fn(l[2:0]);
      sig = ((sig << 1) | 16'(^(sig & 16'hB400))) ^ 16'(d);
      l   = (l << 1) | 16'(^(l & 16'hB400));
    end
  endtask

  task automatic run_main(input logic [15:0] sd, input int hold, input int mid,
                          output int lat, output int ndone);
    @(negedge clk);
    m_if.seed  = sd;
    m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.seed  = 16'($urandom);
    m_if.start = (hold > 1) || (mid == 1);
    lat   = -1;
    ndone = 0;
    got_vecs.delete();
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      m_if.start = ((n + 1) <= (hold - 1)) || ((n + 1) == mid);
      if (n >= M_WARM + 1 && n <= M_WARM + M_NV) got_vecs.push_back(m_core_in);
      if (m_if.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (m_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", m_if.busy); end
    n_checks++;
    if (m_if.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", m_if.done); end
    n_checks++;
    if (m_if.signature !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_sig: got %h expected 0000", m_if.signature); end
    n_checks++;
    if (m_if.vec_cnt !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_vec_cnt: got %h expected 0000", m_if.vec_cnt); end
    n_checks++;
    if (m_core_in !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_core_in: got %b expected 000", m_core_in); end
  endtask

  task automatic test_zero_signature();
    int lat, ndone;
    tied = 1'b1; tie_val = 5'h00;
    run_main(16'($urandom), 1, 0, lat, ndone);
    n_checks++;
    if (lat !== M_WARM + M_NV + M_LAT + 1) begin n_fail++; $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, M_WARM + M_NV + M_LAT + 1); end
    n_checks++;
    if (m_if.signature !== 16'h0000) begin n_fail++; $display("[TB] FAIL zero_sig: got %h expected 0000", m_if.signature); end
    n_checks++;
    if (m_if.vec_cnt !== 16'(M_NV)) begin n_fail++; $display("[TB] FAIL zero_vec_cnt: got %0d expected %0d", m_if.vec_cnt, M_NV); end
  endtask

  task automatic test_small_run();
    int lat;
    lat = -1;
    @(negedge clk);
    s_if.seed  = 16'($urandom);
    s_if.start = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (s_if.done === 1'b1 && lat < 0) lat = n;
    end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("[TB] FAIL small_latency: got %0d expected 4", lat); end
    n_checks++;
    if (s_if.signature !== 16'h0003) begin n_fail++; $display("[TB] FAIL small_sig: got %h expected 0003", s_if.signature); end
  endtask

  task automatic test_seed_zero();
    int lat, ndone, diffs;
    tied = 1'b0;
    run_main(16'h0000, 1, 0, lat, ndone);
    ref_vecs = got_vecs;
    run_main(16'h0001, 1, 0, lat, ndone);
    diffs = 0;
    for (int i = 0; i < M_NV; i++) begin
      if (i >= ref_vecs.size() || i >= got_vecs.size() || ref_vecs[i] !== got_vecs[i]) diffs++;
    end
    n_checks++;
    if (diffs != 0) begin n_fail++; $display("[TB] FAIL seed0_vs_seed1: got %0d differing vectors expected 0", diffs); end
    n_checks++;
    if (ref_vecs.size() < 2 || ref_vecs[0] !== 3'b001 || ref_vecs[1] !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL seed0_first_vecs: got %b %b expected 001 010", ref_vecs[0], ref_vecs[1]);
    end
  endtask

  task automatic test_random_runs();
    int lat, ndone, diffs;
    logic [15:0] sd, exp_sig;
    tied = 1'b0;
    for (int r = 0; r < 3; r++) begin
      sd = 16'($urandom);
      model_run(sd, M_NV, exp_sig);
      run_main(sd, 1, 0, lat, ndone);
      diffs = 0;
      for (int i = 0; i < M_NV; i++) begin
        if (i >= got_vecs.size() || got_vecs[i] !== exp_vecs[i]) diffs++;
      end
      n_checks++;
      if (diffs != 0) begin n_fail++; $display("[TB] FAIL rand_vectors seed %h: got %0d wrong vectors expected 0", sd, diffs); end
      n_checks++;
      if (m_if.signature !== exp_sig) begin n_fail++; $display("[TB] FAIL rand_sig seed %h: got %h expected %h", sd, m_if.signature, exp_sig); end
      n_checks++;
      if (lat !== M_WARM + M_NV + M_LAT + 1 || ndone !== 1) begin
        n_fail++;
        $display("[TB] FAIL rand_done seed %h: got lat %0d pulses %0d expected lat %0d pulses 1", sd, lat, ndone, M_WARM + M_NV + M_LAT + 1);
      end
    end
  endtask

  task automatic test_abort();
    int lat, ndone, found, pulses;
    logic [15:0] sd, exp_sig;
    tied  = 1'b0;
    found = 0;
    @(negedge clk);
    m_if.seed  = 16'($urandom);
    m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(posedge clk); #1;
      if (m_if.vec_cnt === 16'd10) found = 1;
    end
    n_checks++;
    if (found != 1) begin n_fail++; $display("[TB] FAIL abort_reach10: got vec_cnt %0d expected 10 within 100 cycles", m_if.vec_cnt); end
    m_if.abort = 1'b1;
    @(posedge clk); #1;
    m_if.abort = 1'b0;
    n_checks++;
    if (m_if.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", m_if.busy); end
    n_checks++;
    if (m_if.vec_cnt !== 16'd10) begin n_fail++; $display("[TB] FAIL abort_vec_cnt: got %0d expected 10", m_if.vec_cnt); end
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (m_if.done === 1'b1 || m_if.busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("[TB] FAIL abort_quiet: got %0d busy/done cycles expected 0", pulses); end
    sd = 16'($urandom);
    model_run(sd, M_NV, exp_sig);
    run_main(sd, 1, 0, lat, ndone);
    n_checks++;
    if (m_if.signature !== exp_sig || lat !== M_WARM + M_NV + M_LAT + 1) begin
      n_fail++;
      $display("[TB] FAIL abort_rerun: got sig %h lat %0d expected sig %h lat %0d", m_if.signature, lat, exp_sig, M_WARM + M_NV + M_LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ndone;
    logic [15:0] sd, exp_sig;
    tied = 1'b0;
    sd   = 16'($urandom);
    model_run(sd, M_NV, exp_sig);
    run_main(sd, 3, M_WARM + 10, lat, ndone);
    n_checks++;
    if (ndone !== 1) begin n_fail++; $display("[TB] FAIL start_filter_pulses: got %0d expected 1", ndone); end
    n_checks++;
    if (m_if.signature !== exp_sig || lat !== M_WARM + M_NV + M_LAT + 1) begin
      n_fail++;
      $display("[TB] FAIL start_filter_run: got sig %h lat %0d expected sig %h lat %0d", m_if.signature, lat, exp_sig, M_WARM + M_NV + M_LAT + 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    int found;
    tied  = 1'b0;
    found = 0;
    @(negedge clk);
    m_if.seed  = 16'($urandom);
    m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(posedge clk); #1;
      if (m_if.vec_cnt === 16'(M_NV)) found = 1;
    end
    n_checks++;
    if (found != 1 || m_if.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_reach: got found %0d busy %b expected 1 1", found, m_if.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0 || m_core_in !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_ctrl: got busy %b done %b core_in %b expected 0 0 000", m_if.busy, m_if.done, m_core_in);
    end
    n_checks++;
    if (m_if.signature !== 16'h0000 || m_if.vec_cnt !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_data: got sig %h vec_cnt %h expected 0000 0000", m_if.signature, m_if.vec_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test expected completion before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    tied       = 1'b1;
    tie_val    = 5'h00;
    m_if.start = 1'b0;
    m_if.abort = 1'b0;
    m_if.seed  = 16'h0000;
    s_if.start = 1'b0;
    s_if.abort = 1'b0;
    s_if.seed  = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_zero_signature();
    test_small_run();
    test_seed_zero();
    test_random_runs();
    test_abort();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
